// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and its datapath.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        FIN
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand, product and remainder registers with the shift-add / restoring-divide
// step and the sign fix-up, driven by load/step/fix strobes from the sequencer.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;

    logic               ld_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    // mcand holds |A| for multiply and the divisor |B| for divide; acc holds
    // {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        ld_signed = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (ld_signed && opa[WIDTH-1]) ? -opa : opa;
        mag_b     = (ld_signed && opb[WIDTH-1]) ? -opb : opb;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_part  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_part >= {1'b0, mcand_q};
        div_rem   = div_part[WIDTH-1:0] - mcand_q;

        prod_fixed = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
        quot_fixed = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0]
                                                             : acc_q[WIDTH-1:0];
        rem_fixed  = (is_signed_q && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                               : acc_q[2*WIDTH-1:WIDTH];
        res_hi = is_div_q ? rem_fixed  : prod_fixed[2*WIDTH-1:WIDTH];
        res_lo = is_div_q ? quot_fixed : prod_fixed[WIDTH-1:0];

        mcand_d     = mcand_q;
        acc_d       = acc_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;

        if (load) begin
            sign_a_d    = ld_signed & opa[WIDTH-1];
            sign_b_d    = ld_signed & opb[WIDTH-1];
            is_div_d    = op[1];
            is_signed_d = ld_signed;
            if (op[1]) begin
                mcand_d = mag_b;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
            end else begin
                mcand_d = mag_a;
                acc_d   = {{WIDTH{1'b0}}, mag_b};
            end
        end else if (step) begin
            if (is_div_q) begin
                if (div_ge) begin
                    acc_d = {div_rem, acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end else if (fix) begin
            acc_d = {res_hi, res_lo};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q     <= '0;
            acc_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM for the multi-cycle MULT/DIV unit; owns HI/LO, MTHI/MTLO writes,
// and the busy/done/div_zero handshake back to the main CPU control.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               load, step, fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // HI/LO are loaded on the FIX->FIN edge so they are valid while done is high.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wdata;
                if (lo_wr) lo_d = wdata;
                if (start && !abort) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (op[1] && (opb == '0)) begin
                        state_d    = FIN;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = op[1] ? DIV : MUL;
                    end
                end
            end
            MUL, DIV: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                fix     = 1'b1;
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            hi_d       = hi_q;
            lo_d       = lo_q;
            done_d     = 1'b0;
            div_zero_d = 1'b0;
            step       = 1'b0;
            fix        = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO, a
// negedge monitor pops and compares whenever done is presented.
module tb_muldiv_sequencer;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        abort;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .abort    (abort),
        .opa      (opa),
        .opb      (opb),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    mon_e = sb_q.pop_front();
                    check_output("result_hi", hi, mon_e.hi);
                    check_output("result_lo", lo, mon_e.lo);
                    check_output("div_zero", {31'b0, div_zero}, {31'b0, mon_e.dz});
                    check_output("busy_with_done", {31'b0, busy}, 32'd1);
                end
            end else if (div_zero) begin
                checks++;
                errors++;
                $display("[TB] FAIL stray_div_zero: got div_zero=1 expected 0 without done");
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Called one step after the accepting edge; first_cycle is the cycle index at call.
    task automatic wait_done(input int exp_lat, input int first_cycle);
        int cycles;
        int busy_cnt;
        cycles   = first_cycle;
        busy_cnt = 0;
        while (cycles < 100) begin
            if (busy) busy_cnt++;
            if (done) break;
            @(posedge clock); #1;
            cycles++;
        end
        check_output("latency", cycles, exp_lat);
        check_output("busy_cycles", busy_cnt, exp_lat - first_cycle + 1);
        @(posedge clock); #1;
        check_output("busy_after_fin", {31'b0, busy}, 32'd0);
        check_output("done_pulse_width", {31'b0, done}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic dz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = dz;
        sb_q.push_back(e);
        apply_stimulus(o, a, b);
        wait_done(dz ? 1 : 34, 1);
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(posedge clock); #1;
        hi_wr = 1'b1;
        wdata = h;
        @(posedge clock); #1;
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wdata = l;
        @(posedge clock); #1;
        lo_wr = 1'b0;
        check_output("mthi", hi, h);
        check_output("mtlo", lo, l);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        abort = 1'b0;
        opa   = '0;
        opb   = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;

        #23;
        check_output("reset_hi", hi, 32'h0);
        check_output("reset_lo", lo, 32'h0);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(T_MULT,  32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(T_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(T_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        write_hilo(32'h1234, 32'h5678);
        run_op(T_DIV, 32'd77, 32'd0, 32'h1234, 32'h5678, 1'b1);

        // Abort mid-multiply; a start and an MTHI issued while busy are both ignored.
        apply_stimulus(T_MULT, 32'd5, 32'd6);
        repeat (4) begin @(posedge clock); #1; end
        start = 1'b1; op = T_MULTU; opa = 32'd9; opb = 32'd9;
        hi_wr = 1'b1; wdata = 32'hDEAD;
        @(posedge clock); #1;
        start = 1'b0; hi_wr = 1'b0;
        check_output("mthi_while_busy", hi, 32'h1234);
        repeat (4) begin @(posedge clock); #1; end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_output("busy_after_abort", {31'b0, busy}, 32'd0);
        repeat (40) begin @(posedge clock); #1; end
        check_output("hi_after_abort", hi, 32'h1234);
        check_output("lo_after_abort", lo, 32'h5678);

        start = 1'b1; abort = 1'b1; op = T_MULT; opa = 32'd2; opb = 32'd2;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        check_output("abort_blocks_start", {31'b0, busy}, 32'd0);

        // A second start while busy must not replace the first operands.
        sb_q.push_back('{hi: 32'h0, lo: 32'd700, dz: 1'b0});
        apply_stimulus(T_MULT, 32'd100, 32'd7);
        repeat (4) begin @(posedge clock); #1; end
        start = 1'b1; op = T_MULTU; opa = 32'd3; opb = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(34, 6);

        // Asynchronous reset in the middle of a divide.
        apply_stimulus(T_DIV, 32'd100, 32'd7);
        repeat (10) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        check_output("async_reset_hi", hi, 32'h0);
        check_output("async_reset_lo", lo, 32'h0);
        check_output("async_reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        repeat (3) @(posedge clock);
        check_output("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the CPU's integer multiply/divide resource and the HI/LO registers.
- The main control FSM issues one MULT/MULTU/DIV/DIVU with a start pulse. This block runs 32 iterations, then writes HI/LO, and holds busy so the control FSM stalls.
- Also serves MTHI/MTLO direct writes and supplies HI/LO to the MemtoReg mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue request; sampled in IDLE only
- op  in  2  op[1]: 0=mult, 1=div; op[0]: 0=signed, 1=unsigned
- abort  in  1  exception kill; cancels the operation in progress
- opa  in  WIDTH  operand A (rs, from register A)
- opb  in  WIDTH  operand B (rt, from register B)
- hi_wr  in  1  MTHI write enable (HiCtrl)
- lo_wr  in  1  MTLO write enable (LoCtrl)
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on completion
- div_zero  out  1  one-cycle pulse when a divide has a zero divisor
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE; hi=lo=0; busy=done=div_zero=0; counter=0; internal operand registers cleared.
- States: IDLE, MUL, DIV, FIX, FIN.

IDLE:
- start=1 latches opa, opb and op, clears counter, and goes to MUL or DIV.
- start=1 on a divide with opb==0: no iterations. Go to FIN with the zero flag set.
- Signed ops latch operand magnitudes plus sign bits. Unsigned ops latch operands as-is.

MUL:
- One shift-add step per cycle on magnitudes (2*WIDTH product register); counter increments each step.
- After step WIDTH (counter==WIDTH-1) go to FIX.

DIV:
- One restoring step per cycle: shift the remainder/quotient pair left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- After WIDTH steps go to FIX.

FIX (one cycle):
- Signed mult: negate the 64-bit product if sA^sB.
- Signed div: negate the quotient if sA^sB; negate the remainder if sA.
- Unsigned: pass-through.
- Go to FIN.

FIN (one cycle):
- done=1.
- Mult: hi={product[63:32]}, lo={product[31:0]}.
- Div: lo=quotient, hi=remainder. HI/LO update at the same clock edge that enters FIN, so the values are visible while done=1.
- Zero-divisor case: div_zero=1 and done=1; HI/LO unchanged.
- Always returns to IDLE.

Timing and handshake:
- Latency: start accepted at edge t; done high in the cycle after edge t+WIDTH+2 (34 cycles after start for WIDTH=32). Zero-divisor: done and div_zero high in the cycle after edge t+1.
- busy=1 in MUL/DIV/FIX/FIN; 0 in IDLE. busy and done overlap in FIN.

Request handling:
- start while busy: ignored, no queueing.
- hi_wr/lo_wr: honoured only in IDLE (write at the next edge); ignored while busy.
- hi_wr/lo_wr together with an accepted start in IDLE: the direct write happens; the later result overwrites it.
- abort: highest priority after reset. In any non-IDLE state, return to IDLE at the next edge. No done, no HI/LO update, and div_zero is suppressed even if it would fire that cycle. In IDLE, abort blocks acceptance of a simultaneous start.

Arithmetic:
- Signed DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (result of the magnitude algorithm; no trap).
- All arithmetic is modulo 2^WIDTH / 2^(2*WIDTH).

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encoding: IDLE, MUL, DIV, FIX, FIN
  - default WIDTH constant
- One sub-module, muldiv_datapath: operand/product/remainder registers, the shift-add and trial-subtract step, and sign fix-up. Controlled by step/fix/load strobes from the FSM in muldiv_sequencer.

Test Plan:
- MULT opa=0xFFFFFFF9 (−7), opb=3 -> done after 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 34 cycles.
- MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV opa=0xFFFFFFF9, opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opa=0xFFFFFFFF, opb=0x10 -> lo=0x0FFFFFFF, hi=0xF.
- DIV with opb=0 after MTHI 0x1234 / MTLO 0x5678 -> done and div_zero high in the cycle after edge t+1; hi=0x1234, lo=0x5678 unchanged.
- Running MULT, assert abort at cycle 10 -> busy=0 next cycle, no done, HI/LO keep their prior values. A start issued during busy is ignored, and the result matches the first operands.
- Assert reset in the DIV state mid-operation -> hi=lo=0, busy=0 immediately (async). The next start completes normally, including DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
